// File: rtl/hybrid_queue.sv
// rtl/hybrid_queue.sv - first-word-fall-through FIFO with level counter, warning, flush and sticky errors
module hybrid_queue #(
  parameter int DATABITS       = 8,
  parameter int QUEUECNTBITS   = 4,
  parameter int QUEUESIZE      = 2 ** QUEUECNTBITS,
  parameter int QUEUEWARNLEVEL = QUEUESIZE - 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATABITS-1:0]     queue_in,
  input  logic                    queue_push,
  output logic                    queue_full,
  output logic                    queue_warning,
  input  logic                    queue_pop,
  output logic [DATABITS-1:0]     queue_out,
  output logic                    queue_not_empty,
  output logic [QUEUECNTBITS:0]   queue_level,
  input  logic                    queue_flush,
  output logic                    queue_overflow,
  output logic                    queue_underflow
);

  localparam logic [QUEUECNTBITS:0]   LP_SIZE    = (QUEUECNTBITS + 1)'(QUEUESIZE);
  localparam logic [QUEUECNTBITS:0]   LP_WARN    = (QUEUECNTBITS + 1)'(QUEUEWARNLEVEL);
  localparam logic [QUEUECNTBITS:0]   LP_LVL_ONE = (QUEUECNTBITS + 1)'(1);
  localparam logic [QUEUECNTBITS-1:0] LP_PTR_ONE = QUEUECNTBITS'(1);

  logic [DATABITS-1:0]     r_mem [QUEUESIZE];
  logic [QUEUECNTBITS-1:0] r_inaddr;
  logic [QUEUECNTBITS-1:0] r_outaddr;
  logic [QUEUECNTBITS:0]   r_level;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    w_push_ok;
  logic                    w_pop_ok;

  assign queue_full      = (r_level == LP_SIZE);
  assign queue_not_empty = (r_level != '0);
  assign queue_warning   = (r_level >= LP_WARN);
  assign queue_level     = r_level;
  assign queue_out       = r_mem[r_outaddr];
  assign queue_overflow  = r_overflow;
  assign queue_underflow = r_underflow;

  // A pop in the same cycle frees the slot, so a full queue still takes the push.
  assign w_pop_ok  = queue_pop & queue_not_empty;
  assign w_push_ok = queue_push & (~queue_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok && !queue_flush) begin
      r_mem[r_inaddr] <= queue_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inaddr    <= '0;
      r_outaddr   <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (queue_flush) begin
      r_inaddr    <= '0;
      r_outaddr   <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_inaddr <= r_inaddr + LP_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_outaddr <= r_outaddr + LP_PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LP_LVL_ONE;
        2'b01:   r_level <= r_level - LP_LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (queue_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (queue_pop && !queue_not_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hybrid_queue.sv
// tb/tb_hybrid_queue.sv - directed self-checking bench for hybrid_queue
module tb_hybrid_queue;

  logic       clk;
  logic       reset_n;
  logic [7:0] queue_in;
  logic       queue_push;
  logic       queue_full;
  logic       queue_warning;
  logic       queue_pop;
  logic [7:0] queue_out;
  logic       queue_not_empty;
  logic [3:0] queue_level;
  logic       queue_flush;
  logic       queue_overflow;
  logic       queue_underflow;

  int checks;
  int failures;

  hybrid_queue #(
    .DATABITS(8),
    .QUEUECNTBITS(3),
    .QUEUEWARNLEVEL(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .queue_in(queue_in),
    .queue_push(queue_push),
    .queue_full(queue_full),
    .queue_warning(queue_warning),
    .queue_pop(queue_pop),
    .queue_out(queue_out),
    .queue_not_empty(queue_not_empty),
    .queue_level(queue_level),
    .queue_flush(queue_flush),
    .queue_overflow(queue_overflow),
    .queue_underflow(queue_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one clock edge and leaves the bench 1 ns after it with inputs idle.
  task automatic cycle(input logic push, input logic [7:0] data, input logic pop, input logic flush);
    queue_push  = push;
    queue_in    = data;
    queue_pop   = pop;
    queue_flush = flush;
    @(posedge clk);
    #1;
    queue_push  = 1'b0;
    queue_pop   = 1'b0;
    queue_flush = 1'b0;
    queue_in    = 8'h00;
  endtask

  task automatic test_reset();
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", queue_level); end
    checks++; if (queue_not_empty !== 1'b0) begin failures++; $display("FAIL reset_not_empty got=%b exp=0", queue_not_empty); end
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", queue_full); end
    checks++; if (queue_warning !== 1'b0) begin failures++; $display("FAIL reset_warning got=%b exp=0", queue_warning); end
    checks++; if ({queue_overflow, queue_underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {queue_overflow, queue_underflow}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      checks++; if (queue_level !== 4'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, queue_level, i + 1); end
      checks++; if (queue_warning !== (i + 1 >= 5)) begin failures++; $display("FAIL fill_warning[%0d] got=%b exp=%b", i, queue_warning, (i + 1 >= 5)); end
      checks++; if (queue_full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, queue_full, (i == 7)); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (queue_out !== 8'h10 + 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, queue_out, 8'h10 + 8'(i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (queue_not_empty !== 1'b0) begin failures++; $display("FAIL drain_not_empty got=%b exp=0", queue_not_empty); end
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", queue_level); end
    checks++; if (queue_underflow !== 1'b0) begin failures++; $display("FAIL drain_underflow got=%b exp=0", queue_underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (queue_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", queue_overflow); end
    checks++; if (queue_level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", queue_level); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (queue_out !== 8'h20 + 8'(i)) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, queue_out, 8'h20 + 8'(i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (queue_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", queue_overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (queue_overflow !== 1'b0) begin failures++; $display("FAIL ovf_flush_clear got=%b exp=0", queue_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [8];
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    checks++; if (queue_out !== 8'h10) begin failures++; $display("FAIL fpp_head got=%h exp=10", queue_out); end
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (queue_level !== 4'd8) begin failures++; $display("FAIL fpp_level got=%0d exp=8", queue_level); end
    checks++; if (queue_out !== 8'h11) begin failures++; $display("FAIL fpp_new_head got=%h exp=11", queue_out); end
    checks++; if (queue_overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%b exp=0", queue_overflow); end
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int i = 0; i < 8; i++) begin
      checks++; if (queue_out !== exp_seq[i]) begin failures++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, queue_out, exp_seq[i]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_push_pop();
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    checks++; if (queue_underflow !== 1'b1) begin failures++; $display("FAIL epp_underflow got=%b exp=1", queue_underflow); end
    checks++; if (queue_level !== 4'd1) begin failures++; $display("FAIL epp_level got=%0d exp=1", queue_level); end
    checks++; if (queue_out !== 8'h33) begin failures++; $display("FAIL epp_data got=%h exp=33", queue_out); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (queue_underflow !== 1'b0) begin failures++; $display("FAIL epp_flush_clear got=%b exp=0", queue_underflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] model [$];
    int pushed;
    int cyc;
    logic do_push;
    logic do_pop;
    pushed = 0;
    cyc = 0;
    while (pushed < 20 || model.size() > 0) begin
      do_pop  = (model.size() > 0) && ((cyc % 3) != 0 || pushed >= 20);
      do_push = (pushed < 20) && (model.size() < 8 || do_pop);
      if (do_pop) begin
        checks++; if (queue_out !== model[0]) begin failures++; $display("FAIL wrap_data[c%0d] got=%h exp=%h", cyc, queue_out, model[0]); end
        void'(model.pop_front());
      end
      if (do_push) begin
        model.push_back(8'h40 + 8'(pushed));
        pushed++;
      end
      cycle(do_push, 8'h40 + 8'(pushed - 1), do_pop, 1'b0);
      checks++; if (queue_level !== 4'(model.size())) begin failures++; $display("FAIL wrap_level[c%0d] got=%0d exp=%0d", cyc, queue_level, model.size()); end
      cyc++;
    end
    checks++; if ({queue_overflow, queue_underflow} !== 2'b00) begin failures++; $display("FAIL wrap_flags got=%b exp=00", {queue_overflow, queue_underflow}); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    checks++; if (queue_underflow !== 1'b1) begin failures++; $display("FAIL flush_pre_underflow got=%b exp=1", queue_underflow); end
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", queue_level); end
    checks++; if (queue_not_empty !== 1'b0) begin failures++; $display("FAIL flush_not_empty got=%b exp=0", queue_not_empty); end
    checks++; if ({queue_overflow, queue_underflow} !== 2'b00) begin failures++; $display("FAIL flush_flags got=%b exp=00", {queue_overflow, queue_underflow}); end
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    checks++; if (queue_level !== 4'd1) begin failures++; $display("FAIL flush_after_level got=%0d exp=1", queue_level); end
    checks++; if (queue_out !== 8'h12) begin failures++; $display("FAIL flush_after_data got=%h exp=12", queue_out); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    checks++; if (queue_level !== 4'd5) begin failures++; $display("FAIL ar_pre_level got=%0d exp=5", queue_level); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL ar_level got=%0d exp=0", queue_level); end
    checks++; if (queue_not_empty !== 1'b0) begin failures++; $display("FAIL ar_not_empty got=%b exp=0", queue_not_empty); end
    checks++; if ({queue_overflow, queue_underflow, queue_warning} !== 3'b000) begin failures++; $display("FAIL ar_flags got=%b exp=000", {queue_overflow, queue_underflow, queue_warning}); end
    #2;
    reset_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++; if (queue_out !== 8'h77) begin failures++; $display("FAIL ar_first_data got=%h exp=77", queue_out); end
    checks++; if (queue_level !== 4'd1) begin failures++; $display("FAIL ar_first_level got=%0d exp=1", queue_level); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    queue_in    = 8'h00;
    queue_push  = 1'b0;
    queue_pop   = 1'b0;
    queue_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hybrid_queue.md
Name: hybrid_queue

Overview:
Parametrised synchronous FIFO for the hybrid cache request/response paths. It replaces the fixed single-counter queue with:
- explicit pop handshake and full detection
- a level counter one bit wider than the pointers, so full and empty are distinguishable
- programmable warning threshold
- synchronous flush
- sticky overflow/underflow error flags

Sits between cache front-end producers and the memory-side sequencer.

Parameters:
DATABITS, 8, width of one queue entry
QUEUECNTBITS, 4, pointer width; depth is 2**QUEUECNTBITS
QUEUESIZE, 2**QUEUECNTBITS, number of entries (derived, do not override independently)
QUEUEWARNLEVEL, QUEUESIZE-3, level at or above which queue_warning asserts; legal range 1..QUEUESIZE

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
queue_in  in  DATABITS  write data
queue_push  in  1  write request
queue_full  out  1  level == QUEUESIZE
queue_warning  out  1  level >= QUEUEWARNLEVEL
queue_pop  in  1  read acknowledge; consumes the entry shown on queue_out
queue_out  out  DATABITS  head entry (first-word-fall-through)
queue_not_empty  out  1  level != 0
queue_level  out  QUEUECNTBITS+1  current occupancy, 0..QUEUESIZE
queue_flush  in  1  synchronous clear
queue_overflow  out  1  sticky: push attempted while full and not popping
queue_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values:
  - inaddr, outaddr and level go to 0; queue_overflow and queue_underflow go to 0.
  - Hence queue_full=0, queue_not_empty=0, queue_level=0, queue_warning=0 (QUEUEWARNLEVEL>=1).
  - Memory contents are not reset; queue_out is don't-care while empty.
- State: inaddr and outaddr are QUEUECNTBITS wide and wrap modulo QUEUESIZE; level is QUEUECNTBITS+1 wide. All flags decode combinationally from the registered level.
- Push acceptance: push_ok = queue_push & (!queue_full | pop_ok).
  - Accepted push writes queue_in to mem[inaddr] and increments inaddr.
- Pop acceptance: pop_ok = queue_pop & queue_not_empty.
  - Accepted pop increments outaddr.
- Level update each edge:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds QUEUESIZE or drops below 0.
- Full with simultaneous push and pop: both are accepted; level stays QUEUESIZE; no overflow.
- Empty with simultaneous push and pop: pop is ignored and underflow sets; push is accepted; level becomes 1.
- Rejected push (full, no pop): data is dropped, memory and pointers are unchanged, queue_overflow sets.
- Rejected pop (empty): no state change except queue_underflow sets.
- Sticky flags: cleared only by reset or flush.
- Latency: first-word-fall-through.
  - A word pushed at edge N appears on queue_out with queue_not_empty=1 after edge N.
  - queue_out = mem[outaddr], combinational read.
  - After an accepted pop at edge N, the next entry is on queue_out after edge N.
- Flush: queue_flush=1 at an edge zeroes inaddr, outaddr, level and both sticky flags. Flush has priority over push and pop in the same cycle; the push is discarded and no flag sets.
- Wrap-around: pointer rollover from QUEUESIZE-1 to 0 is transparent; ordering is preserved across any number of wraps.
- Reset mid-operation: asserting reset_n low drops all contents immediately (asynchronously). The first edge after release behaves as empty.

Test Plan:
(Bench uses DATABITS=8, QUEUECNTBITS=3, QUEUESIZE=8, QUEUEWARNLEVEL=5.)
- Fill/drain: push 0x10..0x17 on 8 cycles.
  - queue_level counts 1..8; warning rises when level reaches 5; full=1 at 8.
  - Then pop 8 times: queue_out reads 0x10..0x17 in order; not_empty=0 and level=0 at the end.
- Overflow: when full, push 0xAA without pop -> queue_overflow=1, level stays 8, and the next 8 pops return the original data (no 0xAA).
- Full push+pop: when full with head 0x10, push 0x55 and pop in the same cycle -> level stays 8, head becomes 0x11, overflow=0, and 0x55 exits last.
- Empty push+pop: when empty, push 0x33 and pop in the same cycle -> underflow=1, level=1, queue_out=0x33 the next cycle.
- Wrap and flush:
  - Stream 20 words with interleaved push/pop -> order is preserved across the pointer wrap.
  - Then flush with push asserted -> level=0, not_empty=0, overflow=underflow=0, and the pushed word is lost.
- Async reset: with level=5, drop reset_n low between clock edges -> level, not_empty and flags go to 0 without a clock edge. After release, the first push of 0x77 appears on queue_out one edge later.
